// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
package uart_pkg;

    // Transmit scheduler states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        LAT     = 3'd2,
        PRESENT = 3'd3,
        FLUSH   = 3'd4
    } uart_tx_sched_state_t;

    // Read latency of the TX FIFO; the LAT state covers exactly this one cycle
    localparam int UART_TX_SCHED_LAT = 1;

endpackage

// File: rtl/uart_sat_cnt.sv
// uart_sat_cnt: up-counter with synchronous clear that sticks at all-ones.
module uart_sat_cnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority, increment stops at the maximum value
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge i_clk) begin
        cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: moves words from the TX FIFO read port to the bit serializer.
// Issues FIFO reads, absorbs the one-cycle read latency, presents each word on
// a valid/ready handshake, and handles flush, watermark and drained interrupts
// plus a saturating parity-error count.
// Optional build macro UART_TX_SCHED_PERR_DROP_EN: when defined, words that
// arrive with the parity flag set are discarded instead of being presented.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int FIFO_AW = 2,
    parameter int FIFO_DW = 8,
    parameter int PERR_CW = 8
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_enable,
    input  logic               i_flush,
    input  logic [FIFO_AW:0]   i_wm_level,
    output logic               o_fifo_rd_req,
    input  logic [FIFO_DW-1:0] i_fifo_data,
    input  logic               i_fifo_parity_error,
    input  logic               i_fifo_empty,
    input  logic [FIFO_AW:0]   i_fifo_used,
    output logic               o_tx_valid,
    output logic [FIFO_DW-1:0] o_tx_data,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_irq_wm,
    output logic               o_irq_drained,
    output logic               o_flush_done,
    output logic [PERR_CW-1:0] o_perr_cnt
);

    uart_tx_sched_state_t state_q;
    logic                 rd_req_q;
    logic                 tx_valid_q;
    logic [FIFO_DW-1:0]   tx_data_q;
    logic                 irq_wm_q;
    logic                 irq_drained_q;
    logic                 flush_done_q;

    logic refill_ok;
    logic perr_inc;
    logic perr_drop;

    // Another word may be fetched only while enabled and the FIFO has data
    assign refill_ok = i_enable && !i_fifo_empty;

    // Parity flag is only meaningful in the cycle the read data is valid
    assign perr_inc = (state_q == LAT) && i_fifo_parity_error;

`ifdef UART_TX_SCHED_PERR_DROP_EN
    assign perr_drop = i_fifo_parity_error;
`else
    assign perr_drop = 1'b0;
`endif

    // Scheduler FSM with registered outputs; flush overrides every state but FLUSH
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q       <= IDLE;
            rd_req_q      <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            irq_wm_q      <= 1'b0;
            irq_drained_q <= 1'b0;
            flush_done_q  <= 1'b0;
        end else begin
            rd_req_q      <= 1'b0;
            irq_drained_q <= 1'b0;
            flush_done_q  <= 1'b0;
            irq_wm_q      <= (i_fifo_used <= i_wm_level);

            if (i_flush && (state_q != FLUSH)) begin
                // A handshake in this same cycle still completes (valid and
                // ready were both high); otherwise the held word is dropped.
                state_q    <= FLUSH;
                tx_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (refill_ok) begin
                            state_q  <= RD;
                            rd_req_q <= 1'b1;
                        end
                    end
                    RD: begin
                        state_q <= LAT;
                    end
                    LAT: begin
                        if (perr_drop) begin
                            if (refill_ok) begin
                                state_q  <= RD;
                                rd_req_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            tx_data_q  <= i_fifo_data;
                            tx_valid_q <= 1'b1;
                            state_q    <= PRESENT;
                        end
                    end
                    PRESENT: begin
                        if (i_tx_ready) begin
                            tx_valid_q    <= 1'b0;
                            irq_drained_q <= i_fifo_empty;
                            if (refill_ok) begin
                                state_q  <= RD;
                                rd_req_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    FLUSH: begin
                        if (i_fifo_empty) begin
                            flush_done_q <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // While flushing, reads track the live empty flag so late writes drain too
    assign o_fifo_rd_req = rd_req_q || ((state_q == FLUSH) && !i_fifo_empty);
    assign o_tx_valid    = tx_valid_q;
    assign o_tx_data     = tx_data_q;
    assign o_busy        = (state_q != IDLE);
    assign o_irq_wm      = irq_wm_q;
    assign o_irq_drained = irq_drained_q;
    assign o_flush_done  = flush_done_q;

    uart_sat_cnt #(
        .W (PERR_CW)
    ) u_perr_cnt (
        .i_clk (i_clk),
        .i_clr (!i_nrst),
        .i_inc (perr_inc),
        .o_cnt (o_perr_cnt)
    );

endmodule
